debouncer_bank: RTL and testbench
=================================

# debouncer_bank

Parametrised multi-channel input debouncer for the board I/O path: each of `N` asynchronous inputs is synchronised, filtered against a programmable stable time in 100 µs units, and reported as a clean level plus one-cycle rise/fall pulses and sticky event flags. The block replaces the single-channel debouncer. It sits between the raw pad inputs (buttons, switches) and the register/interrupt logic, with per-channel enable and bypass.

## Interface
- `N`, 8: number of channels.
- `TIME_W`, 5: width of `deb_time`.
- `TICK_CYCLES`, 10000: clocks per time unit (100 µs at 100 MHz); ≥2.
- `clk` in 1: system clock, 100 MHz nominal; single clock domain.
- `res` in 1: reset, synchronous, active-high.
- `ena` in N: per-channel filter enable; 0 = bypass.
- `deb_time` in TIME_W: shared debounce time; stable period = (`deb_time`+1)·`TICK_CYCLES` clocks.
- `data_in` in N: raw asynchronous inputs.
- `evt_clr` in N: write-one-to-clear for `evt`.
- `data_out` out N: debounced level, registered.
- `rise` out N: one-cycle pulse on a 0→1 change of `data_out`.
- `fall` out N: one-cycle pulse on a 1→0 change of `data_out`.
- `evt` out N: sticky flag, set by `rise` or `fall`.

## Operation
- Per channel: a 2-FF synchroniser on `data_in` produces `sync`. All logic below uses `sync`.
- `filt` register drives `data_out`.
- Counters per channel: `cyc` (0..TICK_CYCLES-1) and `tim` (TIME_W bits).
- `ena`=1, `sync`==`filt`: `cyc`←0, `tim`←0, `filt` holds.
- `ena`=1, `sync`!=`filt`:
  - `cyc` increments each clock.
  - When `cyc`==TICK_CYCLES-1: `cyc`←0. If `tim`>=`deb_time`, then `filt`←`sync` and `tim`←0; otherwise `tim`←`tim`+1.
- The `>=` comparison is mandatory, so lowering `deb_time` mid-count never wraps the counter.
- A mismatch that disappears for even one clock restarts both counters from 0.
- `ena`=0 (bypass): `filt`←`sync` every clock; `cyc` and `tim` are held at 0.
- Enable toggling: because `filt` already equals `sync` in bypass, asserting `ena` produces no spurious edge.
- `rise`/`fall`: registered compare of `filt` with its previous value. Generated in both modes.
- `evt[i]`: set on `rise[i]|fall[i]`, cleared by `evt_clr[i]`. Set wins over a simultaneous clear.
- Reset: all registers ←0 (synchroniser, `filt`, counters, edge history, `evt`).

## Timing
- Reset values: `data_out`=0, `rise`=0, `fall`=0, `evt`=0.
- Synchroniser latency: 2 clocks.
- `data_out` latency, `ena`=1: `filt` changes exactly (`deb_time`+1)·`TICK_CYCLES` clocks after the first mismatching `sync` cycle, provided the mismatch holds continuously.
- `data_out` latency, bypass: 3 clocks from a `data_in` change (2 sync + 1 `filt`).
- `rise`/`fall`: asserted 1 clock after the `data_out` change, high for exactly 1 clock.
- `evt`: asserted 1 clock after `rise`/`fall`.
- `res` asserted mid-count: all counts are lost and `data_out`→0 on the next clock edge.

## Structure
- Package `debouncer_pkg` holds:
  - default `TIME_W` and `TICK_CYCLES` constants;
  - a `clog2`-based function for `cyc` width, which must hold TICK_CYCLES-1.
- Sub-module `debouncer_chan` (one per channel) contains the synchroniser, `cyc`/`tim` counters, `filt`, edge detection and `evt`.
- Top level `debouncer_bank` is a generate loop over `N` instances sharing `clk`, `res` and `deb_time`.

## Test plan
All scenarios use `N`=4 and `TICK_CYCLES`=4.

- Reset, then `ena`=4'hF, `deb_time`=0, steady `data_in`=0 → `data_out`=0; `rise`, `fall` and `evt` stay 0.
- `deb_time`=2, `data_in[0]` 0→1 held → `data_out[0]`=1 exactly 12 clocks after `sync` changes. `rise[0]` pulses 1 clock later, then `evt[0]`=1.
- Glitch: `data_in[1]` high for 10 clocks then low, `deb_time`=2 → `data_out[1]` stays 0; no pulses.
- Bypass: `ena[2]`=0, toggle `data_in[2]` → `data_out[2]` follows 3 clocks later, with `rise`/`fall` pulses. Reasserting `ena[2]` while stable → no edge.
- Mid-count `deb_time` change 7→1 after `tim`=5 → update on the next tick wrap (no wraparound). Also: `evt_clr[0]` in the same cycle as a new `fall[0]`-driven set → `evt[0]` stays 1.
- `res` pulsed while `data_out[3]`=1 and a count is in progress → next clock: `data_out[3]`=0, `evt`=0, counters restart from 0.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared defaults and helpers for the multi-channel input debouncer.
package debouncer_pkg;

    localparam int DEF_N           = 8;
    localparam int DEF_TIME_W      = 5;
    localparam int DEF_TICK_CYCLES = 10000;

    // Width of the per-channel cycle counter; it must hold tick_cycles-1.
    function automatic int cyc_width(input int tick_cycles);
        return (tick_cycles <= 2) ? 1 : $clog2(tick_cycles);
    endfunction

endpackage

// File: rtl/debouncer_chan.sv
// One debouncer channel: 2-FF synchroniser, tick/time counters, filtered
// level, registered edge pulses and a sticky event flag.
module debouncer_chan
    import debouncer_pkg::*;
#(
    parameter int TIME_W      = DEF_TIME_W,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ena,
    input  logic [TIME_W-1:0] deb_time,
    input  logic              data_in,
    input  logic              evt_clr,
    output logic              data_out,
    output logic              rise,
    output logic              fall,
    output logic              evt
);

    localparam int              CYC_W    = cyc_width(TICK_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYCLES - 1);

    logic              r_meta;
    logic              r_sync;
    logic              r_filt;
    logic              r_filt_d;
    logic [CYC_W-1:0]  r_cyc;
    logic [TIME_W-1:0] r_tim;
    logic              r_rise;
    logic              r_fall;
    logic              r_evt;

    // Bring the raw pad level into the clock domain.
    always_ff @(posedge clk) begin
        if (res) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= data_in;
            r_sync <= r_meta;
        end
    end

    // Filter: a mismatch must persist for (deb_time+1) ticks before the level
    // is accepted. The >= keeps a mid-count deb_time decrease from wrapping.
    always_ff @(posedge clk) begin
        if (res) begin
            r_cyc  <= '0;
            r_tim  <= '0;
            r_filt <= 1'b0;
        end else if (!ena || (r_sync == r_filt)) begin
            r_cyc  <= '0;
            r_tim  <= '0;
            r_filt <= r_sync;
        end else if (r_cyc == CYC_LAST) begin
            r_cyc <= '0;
            if (r_tim >= deb_time) begin
                r_filt <= r_sync;
                r_tim  <= '0;
            end else begin
                r_tim <= r_tim + TIME_W'(1);
            end
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    // Edge pulses from the filtered level, and the sticky event (set wins).
    always_ff @(posedge clk) begin
        if (res) begin
            r_filt_d <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_evt    <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
            r_rise   <= r_filt & ~r_filt_d;
            r_fall   <= ~r_filt & r_filt_d;
            r_evt    <= (r_evt & ~evt_clr) | r_rise | r_fall;
        end
    end

    assign data_out = r_filt;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign evt      = r_evt;

endmodule

// File: rtl/debouncer_bank.sv
// N independent debouncer channels sharing clock, reset and debounce time.
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int TIME_W      = DEF_TIME_W,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic              clk,
    input  logic              res,
    input  logic [N-1:0]      ena,
    input  logic [TIME_W-1:0] deb_time,
    input  logic [N-1:0]      data_in,
    input  logic [N-1:0]      evt_clr,
    output logic [N-1:0]      data_out,
    output logic [N-1:0]      rise,
    output logic [N-1:0]      fall,
    output logic [N-1:0]      evt
);

    // One filter per input pin.
    for (genvar g = 0; g < N; g++) begin : g_chan
        debouncer_chan #(
            .TIME_W      (TIME_W),
            .TICK_CYCLES (TICK_CYCLES)
        ) u_chan (
            .clk      (clk),
            .res      (res),
            .ena      (ena[g]),
            .deb_time (deb_time),
            .data_in  (data_in[g]),
            .evt_clr  (evt_clr[g]),
            .data_out (data_out[g]),
            .rise     (rise[g]),
            .fall     (fall[g]),
            .evt      (evt[g])
        );
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank (N=4, TICK_CYCLES=4). Stimulus queues the
// expected edge pulses with their cycle numbers; a monitor pops and compares
// whenever a rise/fall pulse appears.
module tb_debouncer_bank;

    localparam int N      = 4;
    localparam int TIME_W = 5;
    localparam int TICK   = 4;

    logic              clk = 1'b0;
    logic              res;
    logic [N-1:0]      ena;
    logic [TIME_W-1:0] deb_time;
    logic [N-1:0]      data_in;
    logic [N-1:0]      evt_clr;
    logic [N-1:0]      data_out;
    logic [N-1:0]      rise;
    logic [N-1:0]      fall;
    logic [N-1:0]      evt;

    typedef struct {
        int           cyc;
        logic [N-1:0] r;
        logic [N-1:0] f;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc_cnt = 0;
    int   total   = 0;
    int   bad     = 0;

    debouncer_bank #(
        .N           (N),
        .TIME_W      (TIME_W),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk      (clk),
        .res      (res),
        .ena      (ena),
        .deb_time (deb_time),
        .data_in  (data_in),
        .evt_clr  (evt_clr),
        .data_out (data_out),
        .rise     (rise),
        .fall     (fall),
        .evt      (evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic push(input int c, input logic [N-1:0] rv, input logic [N-1:0] fv);
        exp_t x;
        x.cyc = c;
        x.r   = rv;
        x.f   = fv;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int t);
        while (cyc_cnt < t) @(negedge clk);
    endtask

    // Monitor: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        if ((rise | fall) != '0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_edge: rise=%b fall=%b at cycle %0d, none expected",
                         rise, fall, cyc_cnt);
            end else begin
                m_e = q.pop_front();
                check("edge_cycle", cyc_cnt, m_e.cyc);
                check("rise_vec", int'(rise), int'(m_e.r));
                check("fall_vec", int'(fall), int'(m_e.f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        res      = 1'b1;
        ena      = 4'hF;
        deb_time = '0;
        data_in  = '0;
        evt_clr  = '0;
        step(3);
        check("rst_data_out", int'(data_out), 0);
        check("rst_rise", int'(rise), 0);
        check("rst_fall", int'(fall), 0);
        check("rst_evt", int'(evt), 0);
        res = 1'b0;
        step(10);
        check("idle_data_out", int'(data_out), 0);
        check("idle_evt", int'(evt), 0);

        // ch0: deb_time=2 -> filt 12 clocks after sync changes
        deb_time = 5'd2;
        step(1);
        data_in[0] = 1'b1;
        e = cyc_cnt + 1;
        push(e + 14, 4'b0001, 4'b0000);
        wait_cnt(e + 12); check("ch0_before", int'(data_out[0]), 0);
        wait_cnt(e + 13); check("ch0_after", int'(data_out[0]), 1);
        wait_cnt(e + 14); check("ch0_evt_lag", int'(evt[0]), 0);
        wait_cnt(e + 15); check("ch0_evt_set", int'(evt[0]), 1);
        check("ch0_rise_width", int'(rise[0]), 0);

        // ch1: 10-clock glitch is shorter than 12 -> rejected
        step(2);
        data_in[1] = 1'b1;
        step(10);
        data_in[1] = 1'b0;
        step(30);
        check("ch1_glitch", int'(data_out[1]), 0);
        check("ch1_evt", int'(evt[1]), 0);

        // ch2: bypass, 3-clock latency, then re-enable while stable
        ena[2] = 1'b0;
        step(2);
        data_in[2] = 1'b1;
        e = cyc_cnt + 1;
        push(e + 3, 4'b0100, 4'b0000);
        wait_cnt(e + 1); check("byp_before", int'(data_out[2]), 0);
        wait_cnt(e + 2); check("byp_rise_lvl", int'(data_out[2]), 1);
        step(4);
        data_in[2] = 1'b0;
        e = cyc_cnt + 1;
        push(e + 3, 4'b0000, 4'b0100);
        wait_cnt(e + 1); check("byp_fall_before", int'(data_out[2]), 1);
        wait_cnt(e + 2); check("byp_fall_lvl", int'(data_out[2]), 0);
        step(4);
        ena[2] = 1'b1;
        step(12);
        check("reena_level", int'(data_out[2]), 0);
        evt_clr = 4'b0100;
        step(1);
        evt_clr = '0;
        check("evt_w1c", int'(evt[2]), 0);

        // ch3: deb_time 7 -> 1 after tim reached 5; update on next wrap
        deb_time = 5'd7;
        step(1);
        data_in[3] = 1'b1;
        e = cyc_cnt + 1;
        push(e + 26, 4'b1000, 4'b0000);
        wait_cnt(e + 22); deb_time = 5'd1;
        wait_cnt(e + 24); check("midcnt_before", int'(data_out[3]), 0);
        wait_cnt(e + 25); check("midcnt_update", int'(data_out[3]), 1);

        // ch0: clear coincides with fall-driven set -> set wins
        step(3);
        data_in[0] = 1'b0;
        e = cyc_cnt + 1;
        push(e + 10, 4'b0000, 4'b0001);
        wait_cnt(e + 9);  check("ch0_fall_lvl", int'(data_out[0]), 0);
        wait_cnt(e + 10); evt_clr = 4'b0001;
        wait_cnt(e + 11); check("evt_set_wins", int'(evt[0]), 1);
        step(1);
        evt_clr = '0;
        check("evt_clr_ch0", int'(evt[0]), 0);

        // reset mid-count on ch3 while data_out[3]=1
        step(2);
        data_in[3] = 1'b0;
        step(6);
        check("pre_res_level", int'(data_out[3]), 1);
        res = 1'b1;
        step(1);
        check("res_data_out", int'(data_out), 0);
        check("res_evt", int'(evt), 0);
        res = 1'b0;

        // counters restart from 0 after reset
        step(2);
        data_in[3] = 1'b1;
        e = cyc_cnt + 1;
        push(e + 10, 4'b1000, 4'b0000);
        wait_cnt(e + 8); check("restart_before", int'(data_out[3]), 0);
        wait_cnt(e + 9); check("restart_after", int'(data_out[3]), 1);

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        step(5);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
